// File: rtl/fetch_buffer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_buffer_pkg
// Shared fetch-side types. Provides the PC and instruction widths and the
// entry record carried through the fetch buffer.
// No ports (package).
// -----------------------------------------------------------------------------
package fetch_buffer_pkg;

  localparam int ADDR_WIDTH         = 32;
  localparam int INSN_WIDTH         = 32;
  localparam int FETCH_BUFFER_DEPTH = 4;

  typedef logic [ADDR_WIDTH-1:0] PC;
  typedef logic [INSN_WIDTH-1:0] Instruction;

  typedef struct packed {
    PC          pc;
    Instruction instruction;
    logic       predTaken;
    PC          predPc;
  } FetchBufferEntry;

  // All-zero entry: what decode sees as a bubble (NOP) when the buffer is empty.
  function automatic FetchBufferEntry fetch_buffer_entry_zero();
    FetchBufferEntry e;
    e = '0;
    return e;
  endfunction

endpackage

// File: rtl/fetch_buffer_storage.sv
// -----------------------------------------------------------------------------
// fetch_buffer_storage
// DEPTH x FetchBufferEntry register array: one synchronous write port, one
// asynchronous (combinational) read port, asynchronous clear on reset.
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset, clears every entry
//   i_we     in   write enable
//   i_waddr  in   write index
//   i_wdata  in   entry to write
//   i_raddr  in   read index
//   o_rdata  out  entry at i_raddr (combinational)
// -----------------------------------------------------------------------------
module fetch_buffer_storage
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = FETCH_BUFFER_DEPTH,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_we,
  input  logic [PW-1:0]   i_waddr,
  input  FetchBufferEntry i_wdata,
  input  logic [PW-1:0]   i_raddr,
  output FetchBufferEntry o_rdata
);

  FetchBufferEntry r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// In-order instruction buffer between fetch and decode. Holds up to DEPTH
// entries {pc, instruction, predTaken, predPc}; drains to decode over a
// valid/ready handshake. A flush empties it in one cycle. There is no empty
// bypass: a pushed entry becomes visible the cycle after the push.
// DEPTH must be a power of two and >= 2 so the pointers wrap naturally.
//
// Ports:
//   clk                in   clock, rising edge
//   rst_n              in   asynchronous active-low reset
//   i_flush            in   synchronous flush (highest priority)
//   i_in_valid         in   fetch presents an instruction
//   o_in_ready         out  buffer not full (registered state only)
//   i_in_pc            in   PC of incoming instruction
//   i_in_instruction   in   instruction word
//   i_in_pred_taken    in   predictor said taken
//   i_in_pred_pc       in   predicted target
//   o_out_valid        out  head entry valid (registered state only)
//   i_out_ready        in   decode consumes head this cycle
//   o_out_pc           out  head PC, zero when empty
//   o_out_instruction  out  head instruction, zero when empty
//   o_out_pred_taken   out  head prediction, zero when empty
//   o_out_pred_pc      out  head predicted target, zero when empty
//   o_count            out  occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = FETCH_BUFFER_DEPTH,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [ADDR_WIDTH-1:0] i_in_pc,
  input  logic [INSN_WIDTH-1:0] i_in_instruction,
  input  logic                  i_in_pred_taken,
  input  logic [ADDR_WIDTH-1:0] i_in_pred_pc,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [ADDR_WIDTH-1:0] o_out_pc,
  output logic [INSN_WIDTH-1:0] o_out_instruction,
  output logic                  o_out_pred_taken,
  output logic [ADDR_WIDTH-1:0] o_out_pred_pc,
  output logic [CW-1:0]         o_count
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  logic            w_push;
  logic            w_pop;
  logic            w_we;
  FetchBufferEntry w_wdata;
  FetchBufferEntry w_head;
  FetchBufferEntry w_out;

  // Handshake flags come only from registered count; no pass-through when full.
  assign o_in_ready  = (r_count != FULL_COUNT);
  assign o_out_valid = (r_count != '0);

  assign w_push = i_in_valid  && o_in_ready;
  assign w_pop  = o_out_valid && i_out_ready;

  // A push in a flush cycle is stale; do not even write it.
  assign w_we = w_push && !i_flush;

  assign w_wdata.pc          = i_in_pc;
  assign w_wdata.instruction = i_in_instruction;
  assign w_wdata.predTaken   = i_in_pred_taken;
  assign w_wdata.predPc      = i_in_pred_pc;

  fetch_buffer_storage #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_storage (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rptr),
    .o_rdata (w_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Stale storage behind an empty buffer (e.g. after a flush) must not leak
  // out; decode sees an all-zero NOP instead.
  assign w_out = o_out_valid ? w_head : fetch_buffer_entry_zero();

  assign o_out_pc          = w_out.pc;
  assign o_out_instruction = w_out.instruction;
  assign o_out_pred_taken  = w_out.predTaken;
  assign o_out_pred_pc     = w_out.predPc;
  assign o_count           = r_count;

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction buffer between the fetch stage and the decode stage. It holds up to DEPTH fetched instructions, each with its PC and branch-prediction tag, so a decode-side stall does not stall instruction memory for a full cycle. It drains in order to decode over a valid/ready handshake. A controller flush, issued on branch misprediction or any irregular PC, empties it in one cycle.

## Interface
Parameters:
- DEPTH, default 4: number of entries; must be a power of two and ≥ 2.
- ADDR_WIDTH, default 32: PC width; taken from the shared package.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous flush from the controller.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  buffer accepts this cycle.
- in_pc  in  ADDR_WIDTH  PC of the incoming instruction.
- in_instruction  in  32  instruction word.
- in_pred_taken  in  1  predictor said taken.
- in_pred_pc  in  ADDR_WIDTH  predicted target (BTB result).
- out_valid  out  1  head entry is valid.
- out_ready  in  1  decode consumes the head this cycle.
- out_pc, out_instruction, out_pred_taken, out_pred_pc  out  as the matching in_* fields  head entry fields.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Push = in_valid && in_ready. Pop = out_valid && out_ready.
- in_ready = (count != DEPTH). It depends only on registered count, never on out_ready. There is no pop-to-push pass-through when full.
- out_valid = (count != 0). The out_* fields come straight from the storage entry at the read pointer.
- When count == 0, all out_* data fields read as zero. A zero bubble is a NOP to decode.
- Write pointer and read pointer are each $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- A push writes the entry at the write pointer and increments the write pointer.
- A pop increments the read pointer.
- count changes by +1 on push only, −1 on pop only, and 0 on both or neither.
- There is no empty bypass. An instruction pushed into an empty buffer is not visible until the next cycle.
- flush has the highest priority:
  - Next cycle: count = 0, both pointers = 0.
  - Any push or pop in the flush cycle is discarded.
  - Storage contents need not be cleared.
- Asserting rst, including mid-operation, immediately forces:
  - count = 0, pointers = 0, storage = 0.
  - out_valid = 0, in_ready = 1, all out_* fields = 0.
- No state machine. The state is {write pointer, read pointer, count, storage}.

## Timing
- Latency from push to out_valid is 1 cycle. Throughput is 1 push and 1 pop per cycle.
- in_ready and out_valid are pure functions of registered state. They have no combinational path from in_valid, out_ready or flush.
- Full (count == DEPTH):
  - in_ready = 0 in that same cycle.
  - After a pop, in_ready returns to 1 the following cycle.
- Empty with in_valid and out_ready both high: the push happens, there is no pop, and count becomes 1.
- A flush in the same cycle as a push drops the pushed instruction. The fetch stage is already redirecting via irregPc, so the instruction is stale.
- Reset output values: in_ready = 1, out_valid = 0, count = 0, all out_* fields = 0.

## Structure
- BasicTypes package, additions:
  - FetchBufferEntry struct with fields pc, instruction, predTaken, predPc.
  - FETCH_BUFFER_DEPTH constant, default 4.
- The package already provides ADDR_WIDTH, Instruction and PC. Reuse them.
- Sub-module: fetch_buffer_storage, a DEPTH × FetchBufferEntry register array with one synchronous write port, one asynchronous read port and asynchronous clear. It is the only natural split. Pointer and count logic stay in fetch_buffer.

## Test plan
- Reset then idle: hold rst low for 2 cycles, then release → in_ready = 1, out_valid = 0, count = 0, out_pc = 0.
- Fill to full: push PCs 0x00, 0x04, 0x08, 0x0C with out_ready = 0 →
  - count reaches 4 and in_ready = 0.
  - A fifth push of 0x10 is ignored.
  - out_pc = 0x00.
- Drain in order: from full, hold out_ready = 1 → out_pc sequence 0x00, 0x04, 0x08, 0x0C over 4 cycles, then out_valid = 0 and count = 0.
- Streaming with wrap-around: continuous push and pop for 10 instructions at PC 0x100 + 4·i, starting empty →
  - First output 1 cycle after the first push.
  - count holds at 1.
  - Pointers wrap past DEPTH with no loss or reordering.
- Flush mid-stream: count = 3 plus a simultaneous push of 0x20 and flush = 1 → next cycle count = 0 and out_valid = 0. A following push of 0x40 appears at out_pc one cycle later.
- Async reset mid-operation: count = 2, then rst pulsed low between clock edges → out_valid drops to 0 before the next edge and count = 0.
